adder_arbiter: RTL

//  Shares one 32-bit combinational Adder between NUM_REQ pipeline requesters
//  (e.g. PC+4, branch target, load/store address). Per cycle it grants one requester

---
 rtl/adder_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one external combinational adder between NUM_REQ
// requesters. A lock lets the granted requester keep the adder, and the sum comes back registered.
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           add_in1,
  output logic [WIDTH-1:0]           add_in2,
  input  logic [WIDTH-1:0]           add_out,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_lock_owner;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;

  logic [0:0]         w_state_nxt;
  logic [PTR_W-1:0]   w_rr_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [PTR_W-1:0]   w_scan_idx;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic [NUM_REQ-1:0] w_ready;
  logic [WIDTH-1:0]   w_a [NUM_REQ];
  logic [WIDTH-1:0]   w_b [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a[i] = req_a[i*WIDTH +: WIDTH];
      w_b[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    if (en) begin
      if (r_state == ST_IDLE) begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
          if (req_valid[w_scan_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_scan_idx;
          end
        end
      end else if (req_valid[r_lock_owner]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = r_lock_owner;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_gnt_any) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_lock_owner;
    if (en) begin
      if (r_state == ST_IDLE) begin
        if (w_gnt_any) begin
          w_rr_nxt = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
          if (req_lock[w_gnt_idx]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_gnt_idx;
          end
        end
      end else if (!req_lock[r_lock_owner]) begin
        // Covers both the last locked op and an idle owner giving up the lock.
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_lock_owner <= w_owner_nxt;
      r_rsp_valid  <= w_ready;
      if (w_gnt_any) begin
        r_rsp_data <= add_out;
      end
    end
  end

  assign req_ready = w_ready;
  assign add_in1   = w_gnt_any ? w_a[w_gnt_idx] : '0;
  assign add_in2   = w_gnt_any ? w_b[w_gnt_idx] : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state == ST_LOCKED) | (|r_rsp_valid);

endmodule
